// File: rtl/fft_addr_sequencer_pkg.sv
// rtl/fft_addr_sequencer_pkg.sv - shared constants and state encoding for the FFT address sequencer
package fft_addr_sequencer_pkg;

  localparam int FFT_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } seq_state_e;

  function automatic int half_n(input int addr_bits);
    return 1 << (addr_bits - 1);
  endfunction

  localparam int FFT_HALF_N = half_n(FFT_ADDR_BITS);

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// rtl/fft_bfly_addr_gen.sv - combinational radix-2 butterfly address and twiddle index generator
module fft_bfly_addr_gen
  import fft_addr_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = FFT_ADDR_BITS
) (
  input  logic [3:0]           s_i,
  input  logic [ADDR_BITS-2:0] b_i,
  output logic [ADDR_BITS-1:0] addr_a_o,
  output logic [ADDR_BITS-1:0] addr_b_o,
  output logic [ADDR_BITS-2:0] twiddle_idx_o
);

  localparam logic [3:0] TW_TOP = 4'(ADDR_BITS - 1);

  logic [ADDR_BITS-2:0] pos_mask;
  logic [ADDR_BITS-2:0] pos;
  logic [ADDR_BITS-1:0] span;
  logic [ADDR_BITS-1:0] group_base;

  // Mask of the low s bits; in the last stage every bit of b is position.
  assign pos_mask      = ~({(ADDR_BITS-1){1'b1}} << s_i);
  assign pos           = b_i & pos_mask;
  assign span          = {{(ADDR_BITS-1){1'b0}}, 1'b1} << s_i;
  assign group_base    = ({1'b0, b_i} >> s_i) << (s_i + 4'd1);
  assign addr_a_o      = group_base | {1'b0, pos};
  assign addr_b_o      = addr_a_o | span;
  assign twiddle_idx_o = pos << (TW_TOP - s_i);

endmodule

// File: rtl/fft_addr_sequencer.sv
// rtl/fft_addr_sequencer.sv - in-place radix-2 FFT RAM address and strobe sequencer
module fft_addr_sequencer
  import fft_addr_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = FFT_ADDR_BITS,
  parameter int BFLY_LAT  = 2
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] addrA,
  output logic [ADDR_BITS-1:0] addrB,
  output logic [ADDR_BITS-2:0] twiddle_idx,
  output logic                 bfly_en,
  output logic                 write_enableA,
  output logic                 write_enableB,
  output logic [3:0]           stage,
  output logic                 busy,
  output logic                 done
);

  localparam int                   HALF_N = half_n(ADDR_BITS);
  localparam logic [ADDR_BITS-2:0] LAST_B = (ADDR_BITS-1)'(HALF_N - 1);
  localparam logic [3:0]           LAST_S = 4'(ADDR_BITS - 1);
  localparam logic [2:0]           LAT    = 3'(BFLY_LAT);

  seq_state_e           state_q;
  logic [3:0]           s_q, s_d;
  logic [ADDR_BITS-2:0] b_q, b_d;
  logic [2:0]           wait_q;
  logic [ADDR_BITS-1:0] addr_a_q, addr_b_q;
  logic [ADDR_BITS-2:0] tw_q;
  logic                 bfly_en_q, we_q, busy_q, done_q;

  logic                 last_b, last_bfly;
  logic [3:0]           gen_s;
  logic [ADDR_BITS-2:0] gen_b;
  logic [ADDR_BITS-1:0] gen_addr_a, gen_addr_b;
  logic [ADDR_BITS-2:0] gen_tw;

  assign last_b    = (b_q == LAST_B);
  assign last_bfly = last_b && (s_q == LAST_S);
  assign b_d       = last_b ? '0 : b_q + (ADDR_BITS-1)'(1);
  assign s_d       = last_b ? s_q + 4'd1 : s_q;

  // In WR the generator looks ahead to the next butterfly; in IDLE s_q/b_q are zero.
  assign gen_s = (state_q == ST_WR) ? s_d : s_q;
  assign gen_b = (state_q == ST_WR) ? b_d : b_q;

  fft_bfly_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_addr_gen (
    .s_i          (gen_s),
    .b_i          (gen_b),
    .addr_a_o     (gen_addr_a),
    .addr_b_o     (gen_addr_b),
    .twiddle_idx_o(gen_tw)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      b_q       <= '0;
      wait_q    <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      tw_q      <= '0;
      bfly_en_q <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bfly_en_q <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q  <= ST_IDLE;
        s_q      <= '0;
        b_q      <= '0;
        busy_q   <= 1'b0;
        addr_a_q <= '0;
        addr_b_q <= '0;
        tw_q     <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q  <= ST_RD;
              busy_q   <= 1'b1;
              addr_a_q <= gen_addr_a;
              addr_b_q <= gen_addr_b;
              tw_q     <= gen_tw;
            end
          end
          ST_RD: begin
            state_q   <= ST_WAIT;
            wait_q    <= 3'd1;
            bfly_en_q <= 1'b1;
          end
          ST_WAIT: begin
            if (wait_q == LAT) begin
              state_q <= ST_WR;
              we_q    <= 1'b1;
            end else begin
              wait_q <= wait_q + 3'd1;
            end
          end
          ST_WR: begin
            if (last_bfly) begin
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              s_q      <= '0;
              b_q      <= '0;
              addr_a_q <= '0;
              addr_b_q <= '0;
              tw_q     <= '0;
            end else begin
              state_q  <= ST_RD;
              s_q      <= s_d;
              b_q      <= b_d;
              addr_a_q <= gen_addr_a;
              addr_b_q <= gen_addr_b;
              tw_q     <= gen_tw;
            end
          end
        endcase
      end
    end
  end

  assign addrA         = addr_a_q;
  assign addrB         = addr_b_q;
  assign twiddle_idx   = tw_q;
  assign bfly_en       = bfly_en_q;
  assign write_enableA = we_q;
  assign write_enableB = we_q;
  assign stage         = s_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
